// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master that moves one byte per WR strobe, MSB first, with a 2-bit chip-select register.
// Build option SPI_CLKDIV_EN adds a run-time SCK half-period divider (DIV_WR/DIV_IN).
module spi_byte_engine #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR,
  input  logic [7:0] DIN,
  input  logic       CS_WR,
  input  logic [1:0] CS,
`ifdef SPI_CLKDIV_EN
  input  logic       DIV_WR,
  input  logic [7:0] DIV_IN,
`endif
  input  logic [2:0] MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic [1:0] nSS,
  output logic [7:0] DOUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_sample;
  logic       r_mosi;
  logic       r_sck;
  logic [1:0] r_nss;
  logic [7:0] r_dout;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_reload;
  logic       w_misox;
  logic       w_start;
  logic       w_rise;
  logic       w_fall;
  logic       w_last;

`ifdef SPI_CLKDIV_EN
  logic [7:0] r_div;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div <= DIV_RESET;
    end else if (!r_busy && DIV_WR) begin
      r_div <= DIV_IN;
    end
  end

  assign w_reload = r_div;
`else
  // Fixed half-period of one CLK; the reset divider value has no register to load.
  logic [7:0] w_div_unused;
  assign w_div_unused = DIV_RESET;
  assign w_reload     = 8'd0;
`endif

  // Deselected-all routes the third input so a loopback/idle device can be read.
  assign w_misox = (MISO[0] & ~r_nss[0]) | (MISO[1] & ~r_nss[1]) |
                   (MISO[2] & r_nss[0] & r_nss[1]);

  assign w_start = (r_state == ST_IDLE) && WR;
  assign w_rise  = (r_state == ST_LOW)  && (r_cnt == 8'd0);
  assign w_fall  = (r_state == ST_HIGH) && (r_cnt == 8'd0);
  assign w_last  = w_fall && (r_bitcnt == 3'd7);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (WR)     w_state_nxt = ST_LOW;
      ST_LOW:  if (w_rise) w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_fall) w_state_nxt = w_last ? ST_IDLE : ST_LOW;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= 8'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_sample <= 1'b0;
      r_mosi   <= 1'b0;
      r_sck    <= 1'b0;
      r_nss    <= 2'b11;
      r_dout   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (!r_busy && CS_WR) begin
        r_nss <= CS;
      end
      if (w_start) begin
        r_shift  <= DIN;
        r_mosi   <= DIN[7];
        r_busy   <= 1'b1;
        r_bitcnt <= 3'd0;
        r_cnt    <= w_reload;
      end else if (r_state != ST_IDLE) begin
        if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else begin
          r_cnt <= w_reload;
          if (r_state == ST_LOW) begin
            r_sck    <= 1'b1;
            r_sample <= w_misox;
          end else begin
            r_sck   <= 1'b0;
            r_shift <= {r_shift[6:0], r_sample};
            if (r_bitcnt == 3'd7) begin
              // MOSI keeps the LSB it was driving once the byte is finished.
              r_dout <= {r_shift[6:0], r_sample};
              r_busy <= 1'b0;
            end else begin
              r_mosi   <= r_shift[6];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
      end
    end
  end

  assign MOSI = r_mosi;
  assign SCK  = r_sck;
  assign nSS  = r_nss;
  assign DOUT = r_dout;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: edge-by-edge checks of SCK/MOSI/BUSY/DONE/DOUT/nSS.
// Define SPI_CLKDIV_EN to also exercise the divider.
module tb_spi_byte_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR;
  logic [7:0] DIN;
  logic       CS_WR;
  logic [1:0] CS;
`ifdef SPI_CLKDIV_EN
  logic       DIV_WR;
  logic [7:0] DIV_IN;
`endif
  logic [2:0] MISO;
  logic       MOSI;
  logic       SCK;
  logic [1:0] nSS;
  logic [7:0] DOUT;
  logic       BUSY;
  logic       DONE;

  int n_cmp = 0;
  int n_err = 0;

  spi_byte_engine #(.DIV_RESET(8'd3)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WR    (WR),
    .DIN   (DIN),
    .CS_WR (CS_WR),
    .CS    (CS),
`ifdef SPI_CLKDIV_EN
    .DIV_WR(DIV_WR),
    .DIV_IN(DIV_IN),
`endif
    .MISO  (MISO),
    .MOSI  (MOSI),
    .SCK   (SCK),
    .nSS   (nSS),
    .DOUT  (DOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One transfer starting with WR on the next edge (edge 0). rx is returned on MISO[idx],
  // the other MISO lines carry the complement so a wrong select shows up in DOUT.
  // inj_wr / inj_cs: edge at which a stray WR(8'h12) / CS_WR(2'b01) is sampled (0 = none).
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rx, input int idx, input int h,
                      input logic [1:0] nss_exp, input logic [7:0] dout_prev,
                      input int inj_wr, input int inj_cs);
    int kk;
    int m;
    logic b;
    WR  = 1'b1;
    DIN = tx;
    tick();
    WR  = 1'b0;
    DIN = 8'h00;
    chk("start_busy", BUSY, 1);
    chk("start_mosi", MOSI, tx[7]);
    chk("start_sck", SCK, 0);
    for (int n = 1; n <= 16 * h; n++) begin
      kk = (n / h) / 2;
      if (kk > 7) kk = 7;
      b = rx[7 - kk];
      MISO = {3{~b}};
      MISO[idx] = b;
      if (n == inj_wr) begin
        WR  = 1'b1;
        DIN = 8'h12;
      end
      if (n == inj_cs) begin
        CS_WR = 1'b1;
        CS    = 2'b01;
      end
      tick();
      WR    = 1'b0;
      CS_WR = 1'b0;
      chk("sck", SCK, ((n / h) % 2) == 1);
      chk("nss", nSS, nss_exp);
      if (n < 16 * h) begin
        m = (n / h) / 2;
        chk("mosi", MOSI, tx[7 - m]);
        chk("busy", BUSY, 1);
        chk("done_early", DONE, 0);
        chk("dout_hold", DOUT, dout_prev);
      end else begin
        chk("done_end", DONE, 1);
        chk("busy_end", BUSY, 0);
        chk("dout_end", DOUT, rx);
      end
    end
  endtask

  initial begin
    RST   = 1'b1;
    WR    = 1'b0;
    DIN   = 8'h00;
    CS_WR = 1'b0;
    CS    = 2'b11;
    MISO  = 3'b000;
`ifdef SPI_CLKDIV_EN
    DIV_WR = 1'b0;
    DIV_IN = 8'd0;
`endif
    tick();
    tick();
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_nss", nSS, 2'b11);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_dout", DOUT, 8'h00);
    RST = 1'b0;

`ifdef SPI_CLKDIV_EN
    DIV_WR = 1'b1;
    DIV_IN = 8'd0;
    tick();
    DIV_WR = 1'b0;
`endif

    CS_WR = 1'b1;
    CS    = 2'b10;
    tick();
    CS_WR = 1'b0;
    chk("cs_load", nSS, 2'b10);

    xfer(8'hA5, 8'h3C, 0, 1, 2'b10, 8'h00, 0, 0);
    // Back-to-back: WR lands in the DONE cycle; stray WR and CS_WR mid-transfer are ignored.
    xfer(8'h81, 8'h5A, 0, 1, 2'b10, 8'h3C, 5, 3);
    tick();
    chk("single_done", DONE, 0);
    chk("no_stray_xfer", BUSY, 0);
    chk("nss_kept", nSS, 2'b10);
    chk("dout_idle", DOUT, 8'h5A);

    CS_WR = 1'b1;
    CS    = 2'b01;
    tick();
    CS_WR = 1'b0;
    chk("cs_after_done", nSS, 2'b01);

    xfer(8'h96, 8'hC5, 1, 1, 2'b01, 8'h5A, 0, 0);

    CS_WR = 1'b1;
    CS    = 2'b11;
    tick();
    CS_WR = 1'b0;
    chk("cs_none", nSS, 2'b11);

    xfer(8'hC3, 8'hFF, 2, 1, 2'b11, 8'hC5, 0, 0);
    tick();
    chk("dout_dev2", DOUT, 8'hFF);

    // Abort: reset sampled at edge 7 of a transfer.
    CS_WR = 1'b1;
    CS    = 2'b10;
    tick();
    CS_WR = 1'b0;
    WR    = 1'b1;
    DIN   = 8'h55;
    tick();
    WR    = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    chk("pre_abort_busy", BUSY, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_sck", SCK, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_nss", nSS, 2'b11);
    chk("abort_dout", DOUT, 8'h00);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_done", DONE, 0);
      tick();
    end

`ifdef SPI_CLKDIV_EN
    xfer(8'hE7, 8'h81, 2, 4, 2'b11, 8'h00, 0, 0);
    tick();
    DIV_WR = 1'b1;
    DIV_IN = 8'd2;
    tick();
    DIV_WR = 1'b0;
    xfer(8'hFF, 8'hA6, 2, 3, 2'b11, 8'h81, 0, 0);
    tick();
    chk("div_done_drop", DONE, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
